// File: rtl/prbs5_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module      : prbs5_stream_checker
//  Description : Self-synchronising checker for the 5-bit PRBS stream
//                y(n) = y(n-3) ^ y(n-5), period 31. Fills a 5-bit history,
//                hunts for LOCK_COUNT consecutive good predictions, then
//                counts bit errors while locked, with windowed loss-of-lock
//                and all-zero trap detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module prbs5_stream_checker #(
    parameter int LOCK_COUNT = 10,
    parameter int LOSS_COUNT = 4,
    parameter int WIN_LEN    = 31,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sat,
    output logic             zero_trap
);

    localparam logic [1:0]       c_st_fill   = 2'd0;
    localparam logic [1:0]       c_st_sync   = 2'd1;
    localparam logic [1:0]       c_st_locked = 2'd2;

    localparam logic [7:0]       c_lock_count = 8'(LOCK_COUNT);
    localparam logic [7:0]       c_loss_count = 8'(LOSS_COUNT);
    localparam logic [7:0]       c_win_last   = 8'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] c_cnt_max    = '1;

    logic [1:0]       r_state;
    logic [4:0]       r_hist;
    logic [2:0]       r_fill_cnt;
    logic [7:0]       r_match_cnt;
    logic [7:0]       r_win_cnt;
    logic [7:0]       r_win_err;

    logic             w_pred;
    logic             w_mismatch;
    logic [4:0]       w_hist_next;
    logic             w_hist_zero;
    logic [7:0]       w_match_inc;
    logic [7:0]       w_win_err_inc;
    logic             w_win_end;
    logic             w_err_hit;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_next;

    // Prediction uses the history as it stood before this beat is shifted in.
    assign w_pred        = r_hist[2] ^ r_hist[4];
    assign w_mismatch    = din_valid & (din != w_pred);
    assign w_hist_next   = {r_hist[3:0], din};
    assign w_hist_zero   = (w_hist_next == 5'd0);
    assign w_match_inc   = r_match_cnt + 8'd1;
    assign w_win_err_inc = r_win_err + {7'd0, w_mismatch};
    assign w_win_end     = (r_win_cnt == c_win_last);
    assign w_err_hit     = (r_state == c_st_locked) & w_mismatch;

    // A clear on the same beat as a new error takes effect first, so the
    // error lands on a zero base.
    assign w_cnt_base = err_clr ? '0 : err_count;
    assign w_cnt_next = (w_err_hit && (w_cnt_base != c_cnt_max)) ?
                        (w_cnt_base + CNT_W'(1)) : w_cnt_base;

    // Lock FSM, history shift register and window bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_fill;
            r_hist      <= 5'd0;
            r_fill_cnt  <= 3'd0;
            r_match_cnt <= 8'd0;
            r_win_cnt   <= 8'd0;
            r_win_err   <= 8'd0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            zero_trap   <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            zero_trap <= 1'b0;
            if (din_valid) begin
                r_hist <= w_hist_next;
                case (r_state)
                    c_st_fill: begin
                        if (r_fill_cnt == 3'd4) begin
                            r_fill_cnt <= 3'd0;
                            r_state    <= c_st_sync;
                        end else begin
                            r_fill_cnt <= r_fill_cnt + 3'd1;
                        end
                    end
                    c_st_sync: begin
                        if (w_mismatch || w_hist_zero) begin
                            r_match_cnt <= 8'd0;
                        end else begin
                            r_match_cnt <= w_match_inc;
                            if (w_match_inc == c_lock_count) begin
                                r_state   <= c_st_locked;
                                locked    <= 1'b1;
                                r_win_cnt <= 8'd0;
                                r_win_err <= 8'd0;
                            end
                        end
                    end
                    c_st_locked: begin
                        err_pulse <= w_mismatch;
                        zero_trap <= w_hist_zero;
                        // Window wraps after the final beat has been scored.
                        if (w_win_end) begin
                            r_win_cnt <= 8'd0;
                            r_win_err <= 8'd0;
                        end else begin
                            r_win_cnt <= r_win_cnt + 8'd1;
                            r_win_err <= w_win_err_inc;
                        end
                        if ((w_win_err_inc == c_loss_count) || w_hist_zero) begin
                            r_state     <= c_st_sync;
                            locked      <= 1'b0;
                            r_match_cnt <= 8'd0;
                        end
                    end
                    default: begin
                        r_state <= c_st_fill;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating error counter; survives loss of lock, cleared only by rst/err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
            err_sat   <= 1'b0;
        end else if (err_clr || w_err_hit) begin
            err_count <= w_cnt_next;
            err_sat   <= (w_cnt_next == c_cnt_max);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prbs5_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prbs5_stream_checker
//  Description : Self-checking bench for prbs5_stream_checker. Two instances
//                (16-bit and 2-bit error counters) share one stimulus stream;
//                a behavioural model predicts every output on every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs5_stream_checker;

    localparam int LOCK_COUNT = 10;
    localparam int LOSS_COUNT = 4;
    localparam int WIN_LEN    = 31;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        err_clr = 1'b0;

    logic        locked_a, pulse_a, sat_a, zero_a;
    logic [15:0] cnt_a;
    logic        locked_b, pulse_b, sat_b, zero_b;
    logic [1:0]  cnt_b;

    int n_checks = 0;
    int n_errors = 0;
    int pulses_a = 0;

    always #5 clk = ~clk;

    prbs5_stream_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT),
                           .WIN_LEN(WIN_LEN), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .err_clr(err_clr),
        .locked(locked_a), .err_pulse(pulse_a), .err_count(cnt_a),
        .err_sat(sat_a), .zero_trap(zero_a)
    );

    prbs5_stream_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT),
                           .WIN_LEN(WIN_LEN), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .err_clr(err_clr),
        .locked(locked_b), .err_pulse(pulse_b), .err_count(cnt_b),
        .err_sat(sat_b), .zero_trap(zero_b)
    );

    // Reference PRBS period, built straight from the recurrence.
    logic prbs [0:30];
    int   sidx = 0;

    // Behavioural model: last five received bits plus lock bookkeeping.
    bit   rxq [$];
    int   m_mode;          // 0 = filling, 1 = hunting, 2 = locked
    int   m_streak, m_win_beats, m_win_bad;
    int   m_cnt16, m_cnt2;
    bit   m_sat16, m_sat2, m_pulse, m_zero;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input bit d, input bit c);
        bit expb, bad, allzero;
        if (r) begin
            rxq.delete();
            m_mode = 0; m_streak = 0; m_win_beats = 0; m_win_bad = 0;
            m_cnt16 = 0; m_cnt2 = 0; m_sat16 = 0; m_sat2 = 0;
            m_pulse = 0; m_zero = 0;
            return;
        end
        m_pulse = 0;
        m_zero  = 0;
        if (c) begin
            m_cnt16 = 0; m_cnt2 = 0; m_sat16 = 0; m_sat2 = 0;
        end
        if (!v) return;
        if (m_mode == 0) begin
            rxq.push_back(d);
            if (rxq.size() == 5) m_mode = 1;
            return;
        end
        expb = rxq[2] ^ rxq[0];   // bits received 3 and 5 beats ago
        bad  = (d != expb);
        rxq.push_back(d);
        void'(rxq.pop_front());
        allzero = 1;
        foreach (rxq[i]) if (rxq[i]) allzero = 0;
        if (m_mode == 1) begin
            if (bad || allzero) m_streak = 0;
            else m_streak++;
            if (m_streak == LOCK_COUNT) begin
                m_mode = 2; m_win_beats = 0; m_win_bad = 0;
            end
        end else begin
            m_win_beats++;
            if (bad) begin
                m_pulse = 1;
                m_win_bad++;
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt2 < 3) m_cnt2++;
                m_sat16 = (m_cnt16 == 65535);
                m_sat2  = (m_cnt2 == 3);
            end
            if (m_win_bad >= LOSS_COUNT) begin
                m_mode = 1; m_streak = 0;
            end
            if (m_win_beats == WIN_LEN) begin
                m_win_beats = 0; m_win_bad = 0;
            end
            if (allzero) begin
                m_zero = 1; m_mode = 1; m_streak = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("locked_a",    {31'd0, locked_a}, {31'd0, m_mode == 2});
        check("err_pulse_a", {31'd0, pulse_a},  {31'd0, m_pulse});
        check("err_count_a", {16'd0, cnt_a},    m_cnt16);
        check("err_sat_a",   {31'd0, sat_a},    {31'd0, m_sat16});
        check("zero_trap_a", {31'd0, zero_a},   {31'd0, m_zero});
        check("locked_b",    {31'd0, locked_b}, {31'd0, m_mode == 2});
        check("err_pulse_b", {31'd0, pulse_b},  {31'd0, m_pulse});
        check("err_count_b", {30'd0, cnt_b},    m_cnt2);
        check("err_sat_b",   {31'd0, sat_b},    {31'd0, m_sat2});
        check("zero_trap_b", {31'd0, zero_b},   {31'd0, m_zero});
        if (pulse_a) pulses_a++;
    endtask

    task automatic cycle(input logic r, input logic v, input logic d, input logic c);
        rst = r; din_valid = v; din = d; err_clr = c;
        @(posedge clk);
        model_step(r, v, d, c);
        #1;
        compare_all();
    endtask

    task automatic clean_beats(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b1, prbs[sidx % 31], 1'b0);
            sidx++;
        end
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        sidx = 0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lock_at, vbeats, saved_cnt;
        for (int i = 0; i < 5; i++) prbs[i] = (i % 2 == 0);   // seed 1,0,1,0,1
        for (int i = 5; i < 31; i++) prbs[i] = prbs[i-3] ^ prbs[i-5];

        // Reset state.
        do_reset();
        check("rst_locked", {31'd0, locked_a}, 32'd0);
        check("rst_count",  {16'd0, cnt_a},    32'd0);

        // Contiguous stream: lock after exactly 15 valid beats, no errors.
        lock_at = 0;
        for (int b = 1; b <= 62; b++) begin
            clean_beats(1);
            if (locked_a && lock_at == 0) lock_at = b;
        end
        check("lock_beat", lock_at, 32'd15);
        check("clean_count", {16'd0, cnt_a}, 32'd0);
        check("clean_pulses", pulses_a, 32'd0);

        // Valid toggling: lock timing follows valid beats only.
        do_reset();
        lock_at = 0; vbeats = 0;
        for (int k = 0; k < 124; k++) begin
            if (k % 2 == 0) begin
                clean_beats(1);
                vbeats++;
                if (locked_a && lock_at == 0) lock_at = vbeats;
            end else begin
                cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
        end
        check("lock_beat_gapped", lock_at, 32'd15);

        // Single flipped bit (a 0 turned into 1): three errors, lock held.
        do_reset();
        clean_beats(20);
        for (int i = 0; i < 31 && prbs[sidx % 31] != 1'b0; i++) clean_beats(1);
        pulses_a = 0;
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        sidx++;
        clean_beats(20);
        check("flip_count", {16'd0, cnt_a}, 32'd3);
        check("flip_pulses", pulses_a, 32'd3);
        check("flip_locked", {31'd0, locked_a}, 32'd1);

        // Eight inverted bits: lock lost, regained, count retained.
        clean_beats(40);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, ~prbs[sidx % 31], 1'b0);
            sidx++;
        end
        check("inv_unlocked", {31'd0, locked_a}, 32'd0);
        saved_cnt = m_cnt16;
        clean_beats(25);
        check("inv_relocked", {31'd0, locked_a}, 32'd1);
        check("inv_persist", {16'd0, cnt_a}, saved_cnt);

        // Forced zeros starting where the true stream reads 1,0,0,0.
        clean_beats(40);
        for (int i = 0; i < 31; i++) begin
            if (prbs[(sidx + 30) % 31] == 1'b1 && prbs[sidx % 31] == 1'b0 &&
                prbs[(sidx + 1) % 31] == 1'b0 && prbs[(sidx + 2) % 31] == 1'b0) break;
            clean_beats(1);
        end
        check("pre_zero_locked", {31'd0, locked_a}, 32'd1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("zero_trap", {31'd0, zero_a}, 32'd1);
        check("zero_unlocked", {31'd0, locked_a}, 32'd0);
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("zero_stays_unlocked", {31'd0, locked_a}, 32'd0);

        // Saturation of the 2-bit counter with random data while locked.
        do_reset();
        for (int round = 0; round < 10 && m_cnt2 < 3; round++) begin
            clean_beats(25);
            for (int i = 0; i < 40 && m_mode == 2; i++)
                cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        end
        check("sat_count_b", {30'd0, cnt_b}, 32'd3);
        check("sat_flag_b", {31'd0, sat_b}, 32'd1);

        // Clear coinciding with a locked mismatch leaves a count of one.
        clean_beats(25);
        for (int i = 0; i < 31 && prbs[sidx % 31] != 1'b0; i++) clean_beats(1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        sidx++;
        check("clr_count_b", {30'd0, cnt_b}, 32'd1);
        check("clr_sat_b", {31'd0, sat_b}, 32'd0);
        check("clr_count_a", {16'd0, cnt_a}, 32'd1);

        // Reset while locked, then a fresh fill/lock sequence.
        clean_beats(10);
        check("pre_rst_locked", {31'd0, locked_a}, 32'd1);
        cycle(1'b1, 1'b1, prbs[sidx % 31], 1'b0);
        sidx = 0;
        check("rst_mid_locked", {31'd0, locked_a}, 32'd0);
        check("rst_mid_count", {16'd0, cnt_a}, 32'd0);
        clean_beats(14);
        check("refill_not_locked", {31'd0, locked_a}, 32'd0);
        clean_beats(1);
        check("refill_locked", {31'd0, locked_a}, 32'd1);

        // Random soak: gaps, sparse flips, clears and resets.
        for (int k = 0; k < 3000; k++) begin
            logic v, d, c, r;
            v = ($urandom_range(0, 3) != 0);
            d = prbs[sidx % 31] ^ ($urandom_range(0, 39) == 0);
            c = ($urandom_range(0, 99) == 0);
            r = ($urandom_range(0, 799) == 0);
            cycle(r, v, d, c);
            if (v) sidx++;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prbs5_stream_checker.md
Name: prbs5_stream_checker

Overview:
Receiving end of the 5-bit internal-XOR LFSR pattern generator. It takes the generator's serial output (Sout[4] sampled per beat) as a 1-bit stream with a valid qualifier. It self-synchronises to the sequence y(n) = y(n-3) ^ y(n-5) (period 31), declares lock, then counts bit errors. It is used as the on-chip BIST partner for link and datapath loopback tests in the MIPS16 FPGA build.

Parameters:
LOCK_COUNT, 10, consecutive correct non-degenerate predictions needed to enter LOCKED (range 1..255).
LOSS_COUNT, 4, mismatches within one window that force loss of lock (range 1..WIN_LEN).
WIN_LEN, 31, window length in valid beats for loss-of-lock evaluation (range 2..255).
CNT_W, 16, width of the saturating error counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
din  input  1  received stream bit
din_valid  input  1  din is sampled only on cycles where this is 1
err_clr  input  1  synchronous clear of err_count and sat flag
locked  output  1  checker is in LOCKED state
err_pulse  output  1  one-cycle pulse: a mismatch was detected while LOCKED
err_count  output  CNT_W  saturating count of mismatches while LOCKED
err_sat  output  1  sticky: err_count has reached all-ones
zero_trap  output  1  one-cycle pulse: all-zero history detected while LOCKED

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values: locked=0, err_pulse=0, err_count=0, err_sat=0, zero_trap=0, hist=0, FSM=FILL, all internal counters=0. rst overrides every other input on the same edge.
- hist[4:0]: hist[k] is the bit received k+1 valid beats ago. On each valid beat, hist <= {hist[3:0], din} in every state.
- Prediction for the current beat: pred = hist[2] ^ hist[4]. mismatch = din_valid & (din != pred). The comparison uses hist before the shift.
- Cycles with din_valid=0 leave all state, counters and hist unchanged. err_pulse and zero_trap are 0 on those cycles.
- FILL: fill_cnt counts valid beats. On the 5th valid beat, go to SYNC. No comparisons are made.
- SYNC: on each valid beat:
  - if mismatch, or the post-shift hist==0, then match_cnt <= 0;
  - otherwise match_cnt++. When match_cnt reaches LOCK_COUNT, go to LOCKED and clear win_cnt and win_err.
  - Errors are never counted in SYNC.
- LOCKED:
  - locked=1. It rises in the cycle after the valid beat that completed LOCK_COUNT.
  - Each valid beat: win_cnt++. On mismatch, err_pulse=1 on the next cycle, err_count++ (saturating at 2^CNT_W-1, which sets err_sat), and win_err++.
  - If win_err reaches LOSS_COUNT, go to SYNC, clear match_cnt, and drop locked the next cycle. The beat that triggers loss is still counted.
  - When win_cnt reaches WIN_LEN-1 on a valid beat, win_cnt and win_err wrap to 0 after that beat's update. The loss check happens before the wrap.
  - If the post-shift hist==0, pulse zero_trap, go to SYNC, and clear match_cnt. An all-zero stream never locks.
- err_clr: clears err_count and err_sat. If a LOCKED mismatch occurs on the same beat, the clear wins and then the new error is added, so err_count=1.
- err_count and err_sat persist across lock loss and relock. Only rst and err_clr clear them.
- Latency: din_valid beat to err_pulse/locked/zero_trap is exactly 1 cycle.

Test Plan:
- Generator seeded 5'b10101 feeds 62 contiguous valid beats of Sout[4]. locked rises 1 cycle after beat 15 (5 fill + 10 matches). err_count stays 0 and err_pulse never fires.
- Same stream once locked, with din_valid toggling 1/0 every cycle. Lock timing scales with valid beats only. No errors. Idle cycles leave all outputs unchanged.
- Locked stream with a single bit flipped at one beat. The flip pollutes the predictions that use it at lag 3 and lag 5, giving err_count=3 (flipped beat plus 2 later beats) and 3 err_pulses. locked stays 1 because 3 < LOSS_COUNT=4.
- Locked stream, then 8 consecutive inverted bits inside one window. locked drops 1 cycle after the 4th mismatch. The checker re-locks after 10 clean non-zero matches. err_count retains its value.
- Locked, then din forced to 0 for 5 beats. zero_trap pulses 1 cycle after the 5th zero beat and locked falls. Continued zeros keep locked=0 indefinitely.
- With CNT_W=2: random din while locked saturates err_count at 3 and sets err_sat. err_clr asserted together with a mismatch gives err_count=1 and err_sat=0. rst mid-LOCKED returns all outputs to 0 and the FSM to FILL on the next cycle.
